// File: rtl/mod_const_mul_seq.sv
// Digit-serial (CONST * x) mod MODULUS: one DIGIT_W-bit digit per clock, LSB digit first, via an elaboration-time residue ROM.
// Optional MOD_EARLY_EXIT_EN: finish as soon as the remaining upper digits are all zero.
module mod_const_mul_seq #(
    parameter int MODULUS = 107,
    parameter int CONST   = 37,
    parameter int IN_W    = 18,
    parameter int DIGIT_W = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IN_W-1:0]             in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(MODULUS)-1:0]  out_data,
    output logic                        busy
);

    localparam int MW    = $clog2(MODULUS);
    localparam int NDIG  = (IN_W + DIGIT_W - 1) / DIGIT_W;
    localparam int OPW   = NDIG * DIGIT_W;
    localparam int NENT  = 2 ** DIGIT_W;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int ROM_W = NDIG * NENT * MW;

    // Entry [i][d] = CONST * d * 2^(DIGIT_W*i) mod M, packed flat at address {i, d}.
    function automatic logic [ROM_W-1:0] build_rom();
        logic [ROM_W-1:0]  r;
        longint unsigned   m;
        longint unsigned   c;
        longint unsigned   w;
        longint unsigned   e;
        r = '0;
        m = longint'(MODULUS);
        c = longint'(CONST) % m;
        w = 64'd1 % m;
        for (int i = 0; i < NDIG; i++) begin
            for (int d = 0; d < NENT; d++) begin
                e = (((c * longint'(d)) % m) * w) % m;
                r[(i*NENT + d)*MW +: MW] = MW'(e);
            end
            for (int b = 0; b < DIGIT_W; b++) begin
                w = (w * 64'd2) % m;
            end
        end
        return r;
    endfunction

    localparam logic [ROM_W-1:0] ROM = build_rom();

    // Modular add of two residues; a single conditional subtract suffices since both are < M.
    function automatic logic [MW-1:0] mod_add(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (MW+1)'(MODULUS)) begin
            s = s - (MW+1)'(MODULUS);
        end
        return s[MW-1:0];
    endfunction

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [OPW-1:0]            op;
    logic [MW-1:0]             acc;
    logic [IDX_W-1:0]          idx;
    logic [DIGIT_W-1:0]        digit;
    logic [IDX_W+DIGIT_W-1:0]  rom_addr;
    logic [MW-1:0]             rom_val;
    logic                      last_step;

    // op is shifted down each step, so the current digit is always its low slice.
    assign digit    = op[DIGIT_W-1:0];
    assign rom_addr = {idx, digit};
    assign rom_val  = ROM[int'(rom_addr)*MW +: MW];

`ifdef MOD_EARLY_EXIT_EN
    assign last_step = (idx == IDX_W'(NDIG-1)) || ((op >> DIGIT_W) == '0);
`else
    assign last_step = (idx == IDX_W'(NDIG-1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = ACCUM;
            ACCUM:   if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        out_data  = (state == DONE) ? acc : '0;
    end

    // Accumulator and digit index: cleared on reset and on every accepted operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            idx <= '0;
        end else if (state == IDLE && in_valid) begin
            acc <= '0;
            idx <= '0;
        end else if (state == ACCUM) begin
            acc <= mod_add(acc, rom_val);
            idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            op <= OPW'(in_data);
        end else if (state == ACCUM) begin
            op <= op >> DIGIT_W;
        end
    end

endmodule

// File: tb/tb_mod_const_mul_seq.sv
// Bench for mod_const_mul_seq: directed default-parameter cases plus a random sweep on a
// second instance (M=251, CONST=200, IN_W=20, DIGIT_W=4), checked against plain arithmetic.
module tb_mod_const_mul_seq;

    localparam int M_A = 107, C_A = 37,  W_A = 18, D_A = 6, N_A = 3, MW_A = 7;
    localparam int M_B = 251, C_B = 200, W_B = 20, D_B = 4, N_B = 5, MW_B = 8;
`ifdef MOD_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [W_A-1:0]  a_in_data;
    logic [MW_A-1:0] a_out_data;
    logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [W_B-1:0]  b_in_data;
    logic [MW_B-1:0] b_out_data;

    int n_assert = 0;
    int n_fail   = 0;

    mod_const_mul_seq dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .busy(a_busy)
    );

    mod_const_mul_seq #(.MODULUS(M_B), .CONST(C_B), .IN_W(W_B), .DIGIT_W(D_B)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .busy(b_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_mul(input longint x, input int m, input int c);
        return (longint'(c) * x) % longint'(m);
    endfunction

    // Edges from acceptance to out_valid: fixed NDIG, or highest nonzero digit + 1 (min 1) with early exit.
    function automatic int exp_lat(input longint x, input int dw, input int nd);
        int h;
        h = 0;
        for (int i = 0; i < nd; i++) begin
            if (((x >> (dw*i)) & ((longint'(1) << dw) - 1)) != 0) h = i + 1;
        end
        return EARLY ? ((h < 1) ? 1 : h) : nd;
    endfunction

    task automatic run_a(input logic [W_A-1:0] x, input int hold, input bit poke);
        int n;
        longint exp_d;
        exp_d = ref_mul(longint'(x), M_A, C_A);
        @(negedge clk);
        check("a_idle_ready", a_in_ready, 1);
        a_in_valid = 1'b1;
        a_in_data  = x;
        @(negedge clk);
        if (poke) a_in_data = ~x;
        else a_in_valid = 1'b0;
        check("a_accum_ready", a_in_ready, 0);
        check("a_accum_busy", a_busy, 1);
        n = 0;
        while (!a_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("a_latency", n, exp_lat(longint'(x), D_A, N_A));
        check("a_data", a_out_data, exp_d);
        check("a_done_busy", a_busy, 1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("a_hold_valid", a_out_valid, 1);
            check("a_hold_data", a_out_data, exp_d);
            check("a_hold_ready", a_in_ready, 0);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid  = 1'b0;
        check("a_post_valid", a_out_valid, 0);
        check("a_post_ready", a_in_ready, 1);
        check("a_post_busy", a_busy, 0);
    endtask

    task automatic run_b(input logic [W_B-1:0] x);
        int n;
        longint exp_d;
        exp_d = ref_mul(longint'(x), M_B, C_B);
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data  = x;
        @(negedge clk);
        b_in_valid = 1'b0;
        n = 0;
        while (!b_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b_latency", n, exp_lat(longint'(x), D_B, N_B));
        check("b_data", b_out_data, exp_d);
        check("b_range", (b_out_data < 8'd251), 1);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        check("b_post_ready", b_in_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_busy", a_busy, 0);
        check("rst_b_in_ready", b_in_ready, 1);
        rst = 1'b0;

        run_a(18'd300, 0, 1'b0);
        run_a(18'd3, 0, 1'b0);
        run_a(18'd107, 0, 1'b0);
        run_a(18'd1, 0, 1'b0);
        run_a(18'd0, 0, 1'b0);
        run_a(18'd214, 0, 1'b0);
        run_a(18'd107 * 18'd2449, 0, 1'b0);
        run_a(18'd262143, 5, 1'b1);
        check("a_allones_const", ref_mul(64'd262143, M_A, C_A), 62);

        // Reset in the middle of an accumulation discards the operand.
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = 18'd300;
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready", a_in_ready, 1);
        check("mid_rst_out_valid", a_out_valid, 0);
        check("mid_rst_out_data", a_out_data, 0);
        run_a(18'd1, 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_a(W_A'($urandom), $urandom_range(0, 2), 1'(i % 2));
        end

        run_b(20'd0);
        run_b(20'd251);
        run_b(20'd251 * 20'd4177);
        run_b(20'hFFFFF);
        run_b(20'h0000F);
        for (int i = 0; i < 30; i++) begin
            run_b(W_B'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
